// File: rtl/ps2_keyboard_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard_tx
// Description : Device-side PS/2 keyboard frame transmitter. Scan-code bytes
//               are queued in a small FIFO and each one is serialised onto
//               ps2_clk/ps2_data as an 11-bit frame (start, 8 data LSB first,
//               odd parity, stop), followed by an idle-high gap.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard_tx #(
  parameter int HALF_PERIOD = 4,   // clk cycles per PS/2 clock half-period (>=2)
  parameter int GAP_CYCLES  = 16,  // idle-high clk cycles after each frame (>=1)
  parameter int FIFO_DEPTH  = 4    // queue entries (power of 2, >=2)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_HP_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [c_HP_W-1:0]  c_HP_LAST  = c_HP_W'(HALF_PERIOD - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]         c_LAST_BIT = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BIT_HI = 2'd1,
    S_BIT_LO = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Scan-code queue
  // --------------------------------------------------------------------------
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [c_CNT_W-1:0]  w_count_nxt;
  logic                r_in_ready;
  logic                w_push;
  logic                w_pop;
  logic [7:0]          w_head;

  // --------------------------------------------------------------------------
  // Frame engine
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_HP_W-1:0]   r_hp_cnt;
  logic [c_HP_W-1:0]   w_hp_cnt_nxt;
  logic [3:0]          r_bit_idx;
  logic [3:0]          w_bit_idx_nxt;
  logic [c_GAP_W-1:0]  r_gap_cnt;
  logic [c_GAP_W-1:0]  w_gap_cnt_nxt;
  // Bit 0 of the shifter is the bit currently on ps2_data; ones shift in from
  // the top so the line naturally returns high once the stop bit has gone.
  logic [10:0]         r_shift;
  logic [10:0]         w_shift_nxt;
  logic [10:0]         w_frame;
  logic                r_ps2_clk;
  logic                w_ps2_clk_nxt;
  logic                r_busy;
  logic                w_busy_nxt;

  // in_ready is registered, so a push only depends on last cycle's fullness
  assign w_push  = in_valid & r_in_ready;
  // The FSM only pulls a byte while idle and something is queued
  assign w_pop   = (r_state == S_IDLE) && (r_count != '0);
  assign w_head  = r_mem[r_rd_ptr];
  // start 0, data LSB first, odd parity, stop 1 (bit 0 leaves first)
  assign w_frame = {1'b1, ~^w_head, w_head, 1'b0};

  // Occupancy update: simultaneous push and pop leave the count unchanged
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
      2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Queue storage; contents need no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Queue pointers, count and registered ready flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != c_FULL);
    end
  end

  // Frame FSM state and registered line drivers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_hp_cnt  <= '0;
      r_bit_idx <= '0;
      r_gap_cnt <= '0;
      r_shift   <= '1;
      r_ps2_clk <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hp_cnt  <= w_hp_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ps2_clk <= w_ps2_clk_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic for the frame FSM
  always_comb begin
    w_state_nxt   = r_state;
    w_hp_cnt_nxt  = r_hp_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_gap_cnt_nxt = r_gap_cnt;
    w_shift_nxt   = r_shift;
    w_ps2_clk_nxt = r_ps2_clk;
    w_busy_nxt    = r_busy;

    case (r_state)
      S_IDLE: begin
        w_ps2_clk_nxt = 1'b1;
        if (w_pop) begin
          w_shift_nxt   = w_frame;
          w_busy_nxt    = 1'b1;
          w_hp_cnt_nxt  = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = S_BIT_HI;
        end
      end

      S_BIT_HI: begin
        if (r_hp_cnt == c_HP_LAST) begin
          w_hp_cnt_nxt  = '0;
          w_ps2_clk_nxt = 1'b0;
          w_state_nxt   = S_BIT_LO;
        end else begin
          w_hp_cnt_nxt  = r_hp_cnt + c_HP_W'(1);
        end
      end

      S_BIT_LO: begin
        if (r_hp_cnt == c_HP_LAST) begin
          w_hp_cnt_nxt  = '0;
          w_ps2_clk_nxt = 1'b1;
          w_shift_nxt   = {1'b1, r_shift[10:1]};
          if (r_bit_idx == c_LAST_BIT) begin
            w_gap_cnt_nxt = '0;
            w_state_nxt   = S_GAP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 4'd1;
            w_state_nxt   = S_BIT_HI;
          end
        end else begin
          w_hp_cnt_nxt  = r_hp_cnt + c_HP_W'(1);
        end
      end

      S_GAP: begin
        if (r_gap_cnt == c_GAP_LAST) begin
          w_gap_cnt_nxt = '0;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + c_GAP_W'(1);
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_ps2_clk_nxt = 1'b1;
        w_shift_nxt   = '1;
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  assign in_ready   = r_in_ready;
  assign ps2_clk    = r_ps2_clk;
  assign ps2_data   = r_shift[0];
  assign busy       = r_busy;
  assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ps2_keyboard_tx
// Description : Scoreboard bench for ps2_keyboard_tx. Accepted bytes are
//               queued as expectations; a PS/2 receiver model decodes the
//               lines on ps2_clk falling edges and compares each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_tx;

  localparam int HP    = 4;
  localparam int GAP   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

  // receiver model state
  int          cyc = 0;
  int          bitcnt = 0;
  int          last_fall = 0;
  int          has_prev = 0;
  int          last_interframe = 0;
  int          edges_total = 0;
  int          lowrun = 0;
  int          busyrun = 0;
  int          last_busy_run = 0;
  int          saw_full = 0;
  logic        prev_clk = 1'b1;
  logic [10:0] mon_frame = '0;
  logic [10:0] last_frame = '0;

  ps2_keyboard_tx #(
    .HALF_PERIOD (HP),
    .GAP_CYCLES  (GAP),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // 100 MHz system clock
  initial forever #5 clk = ~clk;

  // cycle counter used for edge spacing
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  // PS/2 receiver model and per-cycle invariants, sampled mid-cycle
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      bitcnt  = 0;
      lowrun  = 0;
      busyrun = 0;
      has_prev = 0;
    end else begin
      chk("ready_vs_count", int'(in_ready), int'(fifo_count < 3'd4));
      chk("count_le_depth", int'(fifo_count <= 3'd4), 1);
      if (fifo_count == 3'd4) saw_full = 1;

      if (busy) busyrun++;
      else begin
        if (busyrun > 0) last_busy_run = busyrun;
        busyrun = 0;
      end

      if (!ps2_clk) lowrun++;
      else begin
        if (lowrun > 0) chk("clk_low_half", lowrun, HP);
        lowrun = 0;
      end

      if (prev_clk && !ps2_clk) begin
        edges_total++;
        if (bitcnt == 0) begin
          if (has_prev != 0) begin
            last_interframe = cyc - last_fall;
            chk("interframe_min", int'(last_interframe >= 2*HP + GAP + 1), 1);
          end
        end else begin
          chk("bit_period", cyc - last_fall, 2*HP);
        end
        last_fall = cyc;
        mon_frame = {ps2_data, mon_frame[10:1]};
        bitcnt++;
        if (bitcnt == 11) begin
          chk("start_bit", int'(mon_frame[0]), 0);
          chk("stop_bit", int'(mon_frame[10]), 1);
          chk("odd_parity", $countones(mon_frame[9:1]) % 2, 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", int'(mon_frame[8:1]), -1);
          end else begin
            e = exp_q.pop_front();
            chk("rx_byte", int'(mon_frame[8:1]), int'(e));
          end
          last_frame = mon_frame;
          bitcnt = 0;
          has_prev = 1;
        end
      end
    end
    prev_clk = ps2_clk;
  end

  // Offer one byte, holding in_valid until accepted; returns at the push edge
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("send_timeout", 1, 0);
    exp_q.push_back(b);
    @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy || fifo_count != 3'd0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_idle_timeout"}, int'(t < 20000), 1);
    repeat (3) @(negedge clk);
  endtask

  // Global watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int t;
    logic [7:0] b;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ps2_clk", int'(ps2_clk), 1);
    chk("rst_ps2_data", int'(ps2_data), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_fifo_count", int'(fifo_count), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // ---- single frame 0x1C: latency, bit pattern, edge count, busy length ----
    e0 = edges_total;
    send(8'h1C);
    #1;
    in_valid = 1'b0;
    chk("lat_count_after_push", int'(fifo_count), 1);
    chk("lat_busy_after_push", int'(busy), 0);
    chk("lat_data_after_push", int'(ps2_data), 1);
    @(posedge clk);
    #1;
    chk("lat_start_data", int'(ps2_data), 0);
    chk("lat_start_busy", int'(busy), 1);
    chk("lat_start_clk", int'(ps2_clk), 1);
    chk("lat_count_popped", int'(fifo_count), 0);
    t = 0;
    while (ps2_clk && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("first_fall_latency", t, HP);
    wait_idle("f1C");
    chk("frame_1C_bits", int'(last_frame), 32'h438);
    chk("frame_1C_edges", edges_total - e0, 11);
    chk("frame_1C_busy_len", last_busy_run, 22*HP + GAP);

    // ---- parity corner cases ----
    send(8'h00);
    drop_valid();
    wait_idle("f00");
    chk("parity_00", int'(last_frame[9]), 1);
    chk("stop_00", int'(last_frame[10]), 1);
    send(8'hFF);
    drop_valid();
    wait_idle("fFF");
    chk("parity_FF", int'(last_frame[9]), 1);
    chk("stop_FF", int'(last_frame[10]), 1);

    // ---- back-to-back / loopback sequence ----
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    drop_valid();
    wait_idle("b2b");
    chk("interframe_exact", last_interframe, 2*HP + GAP + 1);

    // ---- hold in_valid with six bytes: fills queue, nothing lost ----
    saw_full = 0;
    for (int i = 0; i < 6; i++) send(8'h30 + 8'(i));
    drop_valid();
    chk("queue_reached_full", saw_full, 1);
    wait_idle("hold6");

    // ---- randomized traffic ----
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom);
      send(b);
      if ($urandom_range(0, 2) != 0) begin
        drop_valid();
        repeat ($urandom_range(0, 150)) @(negedge clk);
      end
    end
    drop_valid();
    wait_idle("rand");

    // ---- reset during bit 5 of a frame ----
    send(8'hA5);
    send(8'h3C);
    drop_valid();
    t = 0;
    while (bitcnt != 5 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("reach_bit5", int'(t < 500), 1);
    repeat (HP + 2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("abort_ps2_clk", int'(ps2_clk), 1);
    chk("abort_ps2_data", int'(ps2_data), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_fifo_count", int'(fifo_count), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    reset = 1'b0;
    e0 = edges_total;
    repeat (200) @(negedge clk);
    chk("abort_no_edges", edges_total - e0, 0);
    chk("abort_still_idle", int'(busy), 0);

    // ---- traffic resumes cleanly after the abort ----
    send(8'h5A);
    drop_valid();
    wait_idle("post_abort");
    chk("post_abort_byte", int'(last_frame[8:1]), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
